// File: rtl/lfcpnx_evn_pkg.sv
// Shared types and helpers for the LFCPNX-EVN UART receive path.
package lfcpnx_evn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Rounded clock-to-tick divisor, clamped so the tick generator always runs.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        int den;
        int q;
        den = baud * os;
        q   = (clk_hz + den / 2) / den;
        if (q < 1) q = 1;
        return q;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: the head entry is visible combinationally, zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_en  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign level   = LW'(wr_ptr_reg - rd_ptr_reg);
    assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampled majority voting, feeding a show-ahead receive FIFO.
module uart_rx_fifo
    import lfcpnx_evn_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int OVERSAMPLE      = 16,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                              external_clock,
    input  logic                              external_resetn,
    input  logic                              uart_rx,
    output logic [7:0]                        rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              frame_error,
    output logic                              overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
    localparam int DIV      = baud_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam logic [SAMPLE_W-1:0] MID  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] MID1 = SAMPLE_W'(OVERSAMPLE / 2);
    localparam logic [SAMPLE_W-1:0] MID2 = SAMPLE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMPLE_W-1:0] LAST = SAMPLE_W'(OVERSAMPLE - 1);

    logic [1:0]          sync_reg;
    logic                line;
    logic                line_prev_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic                tick;
    uart_rx_state_t      state_reg;
    logic [SAMPLE_W-1:0] sample_cnt_reg;
    logic [3:0]          bit_cnt_reg;
    logic [7:0]          shift_reg;
    logic [1:0]          vote_reg;
    logic                frame_error_reg;
    logic                overrun_reg;

    logic fall;
    logic sample_last;
    logic decide;
    logic majority;
    logic stop_ok;
    logic pop;
    logic push;
    logic fifo_full;
    logic fifo_empty;

    // Reset to idle-high so leaving reset never looks like a start bit.
    always_ff @(posedge external_clock or negedge external_resetn) begin
        if (!external_resetn) begin
            sync_reg      <= 2'b11;
            line_prev_reg <= 1'b1;
        end else begin
            sync_reg      <= {sync_reg[0], uart_rx};
            line_prev_reg <= sync_reg[1];
        end
    end
    assign line = sync_reg[1];

    assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

    always_ff @(posedge external_clock or negedge external_resetn) begin
        if (!external_resetn) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
        end
    end

    assign fall        = line_prev_reg && !line;
    assign sample_last = (sample_cnt_reg == LAST);
    assign decide      = tick && (sample_cnt_reg == MID2);
    assign majority    = (vote_reg[0] & vote_reg[1]) | (vote_reg[0] & line) | (vote_reg[1] & line);
    assign stop_ok     = (state_reg == STOP) && decide && majority;
    assign pop         = rx_valid && rx_ready;
    assign push        = stop_ok && (!fifo_full || pop);

    always_ff @(posedge external_clock or negedge external_resetn) begin
        if (!external_resetn) begin
            state_reg       <= IDLE;
            sample_cnt_reg  <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            vote_reg        <= '0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;

            if (state_reg == IDLE && fall) begin
                sample_cnt_reg <= '0;
            end else if (tick) begin
                sample_cnt_reg <= sample_last ? '0 : sample_cnt_reg + 1'b1;
            end

            if (tick && sample_cnt_reg == MID)  vote_reg[0] <= line;
            if (tick && sample_cnt_reg == MID1) vote_reg[1] <= line;

            case (state_reg)
                IDLE: begin
                    if (fall) state_reg <= START;
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt_reg == MID && line) begin
                            state_reg <= IDLE;
                        end else if (sample_last) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_reg   <= {majority, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end else if (tick && sample_last && bit_cnt_reg == 4'd8) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    // Leaving at the stop mid-point lets the next start edge follow with no gap.
                    if (decide) begin
                        if (majority) begin
                            state_reg   <= IDLE;
                            overrun_reg <= fifo_full && !pop;
                        end else begin
                            frame_error_reg <= 1'b1;
                            state_reg       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (line) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (external_clock),
        .rst_n     (external_resetn),
        .push      (push),
        .push_data (shift_reg),
        .pop       (pop),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign rx_valid    = !fifo_empty;
    assign frame_error = frame_error_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard-checked bytes out.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    // 20 ns clock; divisor 2 at this clock rate gives a 32-cycle bit time.
    localparam real BIT = 640.0;

    logic       clk = 1'b0;
    logic       external_resetn = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic [4:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int bad_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLOCK_FREQUENCY (3_686_400),
        .BAUD_RATE       (115_200),
        .OVERSAMPLE      (16),
        .FIFO_DEPTH      (16)
    ) dut (
        .external_clock  (clk),
        .external_resetn (external_resetn),
        .uart_rx         (uart_rx),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .frame_error     (frame_error),
        .overrun         (overrun),
        .fifo_level      (fifo_level)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        if (frame_error === 1'b1 && overrun === 1'b1) both_cnt <= both_cnt + 1;
        if ((rx_valid !== 1'b1 && rx_data !== 8'h00) || (rx_valid !== (fifo_level != 5'd0)))
            bad_cnt <= bad_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input real bt);
        uart_rx = 1'b0;
        #(bt);
        for (int b = 0; b < 8; b++) begin
            uart_rx = d[b];
            #(bt);
        end
        uart_rx = stop;
        #(bt);
    endtask

    task automatic send_byte(input logic [7:0] d, input real bt);
        exp_q.push_back(d);
        send_frame(d, 1'b1, bt);
    endtask

    task automatic pop_one(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        e = 'x;
        @(negedge clk);
        while (rx_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(rx_valid), 32'd1);
        if (rx_valid === 1'b1) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check({tag, " data"}, 32'(rx_data), 32'(e));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        int fe0;
        int ov0;
        int c;
        logic found;
        logic [7:0] d7;

        // 1: reset with idle line
        repeat (5) @(negedge clk);
        check("t1 valid in reset", 32'(rx_valid), 32'd0);
        external_resetn = 1'b1;
        repeat (10 * 32) @(negedge clk);
        check("t1 valid", 32'(rx_valid), 32'd0);
        check("t1 data", 32'(rx_data), 32'd0);
        check("t1 level", 32'(fifo_level), 32'd0);
        check("t1 frame_error count", 32'(fe_cnt), 32'd0);
        check("t1 overrun count", 32'(ov_cnt), 32'd0);

        // 2: single byte, held until consumer accepts
        @(negedge clk); #1;
        send_byte(8'hA5, BIT);
        @(negedge clk);
        check("t2 valid", 32'(rx_valid), 32'd1);
        check("t2 data", 32'(rx_data), 32'hA5);
        check("t2 level", 32'(fifo_level), 32'd1);
        pop_one("t2 pop");
        check("t2 valid after pop", 32'(rx_valid), 32'd0);
        check("t2 data after pop", 32'(rx_data), 32'd0);

        // 3: framing error, held break, recovery
        fe0 = fe_cnt;
        @(negedge clk); #1;
        send_frame(8'h3C, 1'b0, BIT);
        @(negedge clk);
        check("t3 one frame_error", 32'(fe_cnt - fe0), 32'd1);
        check("t3 level", 32'(fifo_level), 32'd0);
        #(30.0 * BIT);
        @(negedge clk);
        check("t3 break no more errors", 32'(fe_cnt - fe0), 32'd1);
        uart_rx = 1'b1;
        #(2.0 * BIT);
        @(negedge clk); #1;
        send_byte(8'h01, BIT);
        pop_one("t3 recover");
        check("t3 errors after recovery", 32'(fe_cnt - fe0), 32'd1);

        // 4: short glitch on the line
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        uart_rx = 1'b1;
        repeat (64) @(negedge clk);
        check("t4 level", 32'(fifo_level), 32'd0);
        check("t4 frame_error", 32'(fe_cnt - fe0), 32'd0);
        check("t4 overrun", 32'(ov_cnt - ov0), 32'd0);
        #1;
        send_byte(8'hC3, BIT);
        pop_one("t4 follow-up");

        // 5: 17 back-to-back bytes into a 16-entry FIFO
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        @(negedge clk); #1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), BIT);
        check("t5 level full", 32'(fifo_level), 32'd16);
        check("t5 no early overrun", 32'(ov_cnt - ov0), 32'd0);
        send_frame(8'h10, 1'b1, BIT);
        @(negedge clk);
        check("t5 one overrun", 32'(ov_cnt - ov0), 32'd1);
        check("t5 level after overrun", 32'(fifo_level), 32'd16);
        check("t5 no frame_error", 32'(fe_cnt - fe0), 32'd0);
        for (int i = 0; i < 16; i++) pop_one($sformatf("t5 drain %0d", i));
        check("t5 level drained", 32'(fifo_level), 32'd0);

        // 6: pop coinciding with the push into a full FIFO
        ov0 = ov_cnt;
        @(negedge clk); #1;
        for (int i = 0; i < 15; i++) send_byte(8'(8'h20 + i), BIT);
        c = 0;
        found = 1'b0;
        fork
            send_byte(8'h2F, BIT);
            begin
                for (int k = 1; k <= 318 && !found; k++) begin
                    @(negedge clk);
                    if (fifo_level != 5'd15) begin
                        c = k;
                        found = 1'b1;
                    end
                end
            end
        join
        check("t6 push seen", 32'(found), 32'd1);
        check("t6 level full", 32'(fifo_level), 32'd16);
        fork
            send_byte(8'h30, BIT);
            begin
                repeat (c - 1) @(negedge clk);
                check("t6 head at pop", 32'(rx_data), 32'(exp_q.pop_front()));
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("t6 level stays 16", 32'(fifo_level), 32'd16);
        check("t6 no overrun", 32'(ov_cnt - ov0), 32'd0);
        for (int i = 0; i < 16; i++) pop_one($sformatf("t6 drain %0d", i));

        // 7: asynchronous reset in the middle of a frame
        @(negedge clk); #1;
        send_byte(8'h11, BIT);
        @(negedge clk);
        check("t7 level before reset", 32'(fifo_level), 32'd1);
        #1;
        d7 = 8'h96;
        uart_rx = 1'b0;
        #(BIT);
        for (int b = 0; b < 3; b++) begin
            uart_rx = d7[b];
            #(BIT);
        end
        uart_rx = d7[3];
        #(BIT / 2.0);
        external_resetn = 1'b0;
        #1;
        check("t7 valid in reset", 32'(rx_valid), 32'd0);
        check("t7 data in reset", 32'(rx_data), 32'd0);
        check("t7 level in reset", 32'(fifo_level), 32'd0);
        check("t7 pulses in reset", 32'({frame_error, overrun}), 32'd0);
        exp_q.delete();
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        external_resetn = 1'b1;
        repeat (64) @(negedge clk);
        #1;
        send_byte(8'h5A, BIT);
        pop_one("t7 after reset");
        check("t7 level", 32'(fifo_level), 32'd0);

        // 8: bit period skewed by +3% and -3%
        for (int i = 0; i < 48; i++) begin
            send_byte(8'(i * 5), BIT * 1.03);
            pop_one($sformatf("t8 slow %0d", i));
        end
        for (int i = 0; i < 48; i++) begin
            send_byte(8'(255 - i * 5), BIT * 0.97);
            pop_one($sformatf("t8 fast %0d", i));
        end

        @(negedge clk);
        check("frame_error with overrun", 32'(both_cnt), 32'd0);
        check("empty/level consistency", 32'(bad_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
